// File: rtl/uart_modem_status_ctrl.sv
// Modem-status controller: synchronises and debounces the four modem pins,
// keeps the MSR status/delta bits (with loopback substitution) and drives the modem-status IRQ.
module uart_modem_status_ctrl #(
    parameter int FILTER_LEN = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       CTSN,
    input  logic       DSRN,
    input  logic       RIN,
    input  logic       DCDN,
    input  logic       LOOP,
    input  logic       RTS,
    input  logic       DTR,
    input  logic       OUT1,
    input  logic       OUT2,
    input  logic       MSR_RD,
    input  logic       EDSSI,
    output logic [7:0] MSR,
    output logic       INT
);

    localparam int            CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    // Bit order everywhere: [3]=DCD, [2]=RI, [1]=DSR, [0]=CTS (matches MSR[7:4]).
    logic [3:0]    pin;
    logic [3:0]    s0;
    logic [3:0]    s1;
    logic [3:0]    filt;
    logic [CW-1:0] cnt [4];
    logic [3:0]    sel;
    logic [3:0]    status;
    logic [3:0]    delta;
    logic [3:0]    delta_set;

    assign pin = ~{DCDN, RIN, DSRN, CTSN};

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= pin;
            s1 <= s0;
        end
    end

    // A level is accepted only after it has differed from filt for FILTER_LEN consecutive cycles.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            filt <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s1[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= s1[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        sel       = LOOP ? {OUT2, OUT1, DTR, RTS} : filt;
        delta_set = {sel[3] ^ status[3],
                     status[2] & ~sel[2],
                     sel[1] ^ status[1],
                     sel[0] ^ status[0]};
    end

    // A delta raised on the same edge as a read survives the read-clear.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            status <= '0;
            delta  <= '0;
        end else begin
            status <= sel;
            delta  <= (MSR_RD ? 4'b0000 : delta) | delta_set;
        end
    end

    assign MSR = {status, delta};
    assign INT = EDSSI & (|delta);

endmodule

// File: tb/tb_uart_modem_status_ctrl.sv
// Self-checking bench for uart_modem_status_ctrl: directed timing scenarios plus
// randomized traffic compared against a sample-history reference model.
module tb_uart_modem_status_ctrl;

    localparam int FL = 4;

    logic       CLK;
    logic       RSTN;
    logic       CTSN, DSRN, RIN, DCDN;
    logic       LOOP, RTS, DTR, OUT1, OUT2;
    logic       MSR_RD, EDSSI;
    logic [7:0] MSR;
    logic       INT;

    int n_cmp = 0;
    int n_bad = 0;

    uart_modem_status_ctrl #(.FILTER_LEN(FL)) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .CTSN   (CTSN),
        .DSRN   (DSRN),
        .RIN    (RIN),
        .DCDN   (DCDN),
        .LOOP   (LOOP),
        .RTS    (RTS),
        .DTR    (DTR),
        .OUT1   (OUT1),
        .OUT2   (OUT2),
        .MSR_RD (MSR_RD),
        .EDSSI  (EDSSI),
        .MSR    (MSR),
        .INT    (INT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: raw samples per edge, a filtered level that flips once the
    // synchronised input has shown the same new value for FL consecutive edges.
    logic [3:0] rawq[$];
    logic [3:0] m_filt;
    logic [3:0] prev_fin;
    int         run_len [4];
    logic [7:0] m_msr;

    task automatic model_reset();
        rawq.delete();
        m_filt   = '0;
        prev_fin = '0;
        for (int p = 0; p < 4; p++) run_len[p] = 0;
        m_msr = '0;
    endtask

    task automatic model_step();
        logic [3:0] raw;
        logic [3:0] fin;
        logic [3:0] nw;
        logic [3:0] d;
        raw = ~{DCDN, RIN, DSRN, CTSN};
        fin = (rawq.size() >= 2) ? rawq[rawq.size() - 2] : 4'b0000;
        nw  = LOOP ? {OUT2, OUT1, DTR, RTS} : m_filt;
        d   = MSR_RD ? 4'b0000 : m_msr[3:0];
        if (nw[0] != m_msr[4]) d[0] = 1'b1;
        if (nw[1] != m_msr[5]) d[1] = 1'b1;
        if (nw[3] != m_msr[7]) d[3] = 1'b1;
        if (m_msr[6] && !nw[2]) d[2] = 1'b1;
        m_msr = {nw, d};
        for (int p = 0; p < 4; p++) begin
            run_len[p] = (fin[p] == prev_fin[p]) ? run_len[p] + 1 : 1;
            if (run_len[p] >= FL && fin[p] != m_filt[p]) m_filt[p] = fin[p];
        end
        prev_fin = fin;
        rawq.push_back(raw);
        if (rawq.size() > 2) void'(rawq.pop_front());
    endtask

    // One clock: inputs already driven at the preceding negedge; sample at the next negedge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic idle_inputs();
        CTSN = 1'b1; DSRN = 1'b1; RIN = 1'b1; DCDN = 1'b1;
        LOOP = 1'b0; RTS = 1'b0; DTR = 1'b0; OUT1 = 1'b0; OUT2 = 1'b0;
        MSR_RD = 1'b0; EDSSI = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        RSTN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (MSR !== 8'h00) begin
            $display("FAIL reset_msr: got %02h want 00", MSR); n_bad++;
        end
        n_cmp++;
        if (INT !== 1'b0) begin
            $display("FAIL reset_int: got %b want 0", INT); n_bad++;
        end
    endtask

    task automatic test_cts_latency();
        do_reset();
        CTSN = 1'b0;
        tick(FL + 2);
        n_cmp++;
        if (MSR !== 8'h00) begin
            $display("FAIL cts_early: got %02h want 00", MSR); n_bad++;
        end
        tick(1);
        n_cmp++;
        if (MSR !== 8'h11 || INT !== 1'b1) begin
            $display("FAIL cts_arrive: got msr=%02h int=%b want 11/1", MSR, INT); n_bad++;
        end
        MSR_RD = 1'b1;
        tick(1);
        MSR_RD = 1'b0;
        n_cmp++;
        if (MSR !== 8'h10 || INT !== 1'b0) begin
            $display("FAIL cts_read_clear: got msr=%02h int=%b want 10/0", MSR, INT); n_bad++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        DCDN = 1'b0;
        tick(FL - 1);
        DCDN = 1'b1;
        tick(10);
        n_cmp++;
        if (MSR !== 8'h00) begin
            $display("FAIL glitch_short: got %02h want 00", MSR); n_bad++;
        end
        do_reset();
        DCDN = 1'b0;
        tick(FL);
        DCDN = 1'b1;
        tick(3);
        n_cmp++;
        if (MSR !== 8'h88) begin
            $display("FAIL glitch_exact: got %02h want 88", MSR); n_bad++;
        end
        tick(FL);
        n_cmp++;
        if (MSR !== 8'h08) begin
            $display("FAIL glitch_release: got %02h want 08", MSR); n_bad++;
        end
    endtask

    task automatic test_ri_trailing();
        do_reset();
        RIN = 1'b0;
        tick(FL + 3);
        n_cmp++;
        if (MSR !== 8'h40) begin
            $display("FAIL ri_rise: got %02h want 40", MSR); n_bad++;
        end
        MSR_RD = 1'b1;
        tick(1);
        MSR_RD = 1'b0;
        n_cmp++;
        if (MSR !== 8'h40) begin
            $display("FAIL ri_after_read: got %02h want 40", MSR); n_bad++;
        end
        RIN = 1'b1;
        tick(FL + 3);
        n_cmp++;
        if (MSR !== 8'h04 || INT !== 1'b1) begin
            $display("FAIL ri_fall: got msr=%02h int=%b want 04/1", MSR, INT); n_bad++;
        end
    endtask

    task automatic test_loopback();
        do_reset();
        LOOP = 1'b1; RTS = 1'b1; DTR = 1'b1; OUT1 = 1'b0; OUT2 = 1'b1;
        tick(1);
        n_cmp++;
        if (MSR !== 8'hBB) begin
            $display("FAIL loop_enter: got %02h want BB", MSR); n_bad++;
        end
        LOOP = 1'b0;
        tick(1);
        n_cmp++;
        if (MSR !== 8'h0B) begin
            $display("FAIL loop_exit: got %02h want 0B", MSR); n_bad++;
        end
    endtask

    task automatic test_collision();
        do_reset();
        CTSN = 1'b0;
        tick(FL + 3);
        DSRN = 1'b0;
        tick(FL + 2);
        MSR_RD = 1'b1;
        tick(1);
        MSR_RD = 1'b0;
        n_cmp++;
        if (MSR !== 8'h32) begin
            $display("FAIL collision: got %02h want 32", MSR); n_bad++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        CTSN = 1'b0;
        tick(FL + 3);
        DCDN = 1'b0;
        tick(4);
        #2 RSTN = 1'b0;
        #1;
        n_cmp++;
        if (MSR !== 8'h00 || INT !== 1'b0) begin
            $display("FAIL async_reset: got msr=%02h int=%b want 00/0", MSR, INT); n_bad++;
        end
        @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
        tick(FL + 2);
        n_cmp++;
        if (MSR !== 8'h00) begin
            $display("FAIL post_reset_early: got %02h want 00", MSR); n_bad++;
        end
        tick(1);
        n_cmp++;
        if (MSR !== 8'h99 || INT !== 1'b1) begin
            $display("FAIL post_reset_arrive: got msr=%02h int=%b want 99/1", MSR, INT); n_bad++;
        end
    endtask

    task automatic test_random();
        logic exp_int;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) CTSN = ~CTSN;
            if ($urandom_range(7) == 0) DSRN = ~DSRN;
            if ($urandom_range(7) == 0) RIN  = ~RIN;
            if ($urandom_range(7) == 0) DCDN = ~DCDN;
            if ($urandom_range(39) == 0) LOOP = ~LOOP;
            if ($urandom_range(3) == 0) {OUT2, OUT1, DTR, RTS} = 4'($urandom);
            if ($urandom_range(9) == 0) EDSSI = ~EDSSI;
            MSR_RD = ($urandom_range(5) == 0);
            tick(1);
            exp_int = EDSSI & (|m_msr[3:0]);
            n_cmp++;
            if (MSR !== m_msr || INT !== exp_int) begin
                $display("FAIL random[%0d]: got msr=%02h int=%b want %02h/%b",
                         i, MSR, INT, m_msr, exp_int);
                n_bad++;
            end
        end
        MSR_RD = 1'b0;
    endtask

    initial begin
        idle_inputs();
        RSTN = 1'b0;
        model_reset();
        test_reset();
        test_cts_latency();
        test_glitch();
        test_ri_trailing();
        test_loopback();
        test_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
